// File: rtl/data_memory.sv
// Word-addressed 32-bit data memory: combinational read, synchronous write, reset loads mem[i] = i.
// Define DMEM_WRITE_BYPASS_EN to forward write_data to read_data during a simultaneous read+write.
module data_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        memread,
    input  logic        memwrite,
    output logic [31:0] read_data
);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              wr_en;
    logic              unused_addr_hi;

    // Upper address bits deliberately alias onto the low index.
    assign idx            = address[ADDR_W-1:0];
    assign unused_addr_hi = ^address[31:ADDR_W];
    assign wr_en          = memwrite & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'(i);
            end
        end else if (wr_en) begin
            mem[idx] <= write_data;
        end
    end

    always_comb begin
        read_data = 32'h0;
        if (memread) begin
`ifdef DMEM_WRITE_BYPASS_EN
            if (wr_en) begin
                read_data = write_data;
            end else begin
                read_data = mem[idx];
            end
`else
            read_data = mem[idx];
`endif
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory against an array-based reference model.
// Build with +define+DMEM_WRITE_BYPASS_EN to check the bypass variant.
`timescale 1ns/100ps
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        memread;
    logic        memwrite;
    logic [31:0] read_data;

    int n_checks;
    int n_fail;

    logic [31:0] ref_mem [256];

`ifdef DMEM_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    data_memory #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .write_data (write_data),
        .memread    (memread),
        .memwrite   (memwrite),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_read();
        logic [31:0] r;
        r = 32'h0;
        if (memread) begin
            if (BYPASS && memwrite && rst_n) r = write_data;
            else r = ref_mem[address % 256];
        end
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
    endfunction

    // Advance through one rising edge, applying the model write rule.
    task automatic edge_step();
        @(posedge clk);
        if (rst_n && memwrite) ref_mem[address % 256] = write_data;
        #1;
    endtask

    task automatic drive(input logic mr, input logic mw,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        memread    = mr;
        memwrite   = mw;
        address    = a;
        write_data = wd;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        memread  = 1'b1;
        memwrite = 1'b0;
        address  = 32'd1;
        #1;
        n_checks++;
        if (read_data !== 32'h00000001) begin
            n_fail++;
            $display("FAIL reset_addr1 got %h want %h", read_data, 32'h1);
        end
        address = 32'd8;
        #1;
        n_checks++;
        if (read_data !== 32'h00000008) begin
            n_fail++;
            $display("FAIL reset_addr8 got %h want %h", read_data, 32'h8);
        end
        for (int k = 0; k < 4; k++) begin
            a = $urandom;
            address = a;
            #1;
            n_checks++;
            if (read_data !== {24'h0, a[7:0]}) begin
                n_fail++;
                $display("FAIL reset_rand a=%h got %h want %h",
                         a, read_data, {24'h0, a[7:0]});
            end
        end
        memread = 1'b0;
        #1;
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd_off got %h want 0", read_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 32'd1, 32'hFFFFFFFE);
        edge_step();
        drive(1'b1, 1'b0, 32'd1, 32'h0);
        n_checks++;
        if (read_data !== 32'hFFFFFFFE) begin
            n_fail++;
            $display("FAIL wr_rd_addr1 got %h want %h", read_data, 32'hFFFFFFFE);
        end
        address = 32'd2;
        #1;
        n_checks++;
        if (read_data !== 32'h00000002) begin
            n_fail++;
            $display("FAIL wr_rd_addr2 got %h want %h", read_data, 32'h2);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_pre;
        exp_pre = BYPASS ? 32'hFFFFFFFD : 32'h00000002;
        drive(1'b1, 1'b1, 32'd2, 32'hFFFFFFFD);
        n_checks++;
        if (read_data !== exp_pre) begin
            n_fail++;
            $display("FAIL rw_pre_edge got %h want %h", read_data, exp_pre);
        end
        edge_step();
        n_checks++;
        if (read_data !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL rw_post_edge got %h want %h", read_data, 32'hFFFFFFFD);
        end
        memwrite = 1'b0;
        #1;
        n_checks++;
        if (read_data !== 32'hFFFFFFFD) begin
            n_fail++;
            $display("FAIL rw_after got %h want %h", read_data, 32'hFFFFFFFD);
        end
    endtask

    task automatic test_read_disable();
        drive(1'b0, 1'b0, 32'd4, 32'h0);
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_off got %h want 0", read_data);
        end
        drive(1'b0, 1'b1, 32'd4, 32'hFFFFFFFB);
        n_checks++;
        if (read_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rd_off_wr got %h want 0", read_data);
        end
        edge_step();
        drive(1'b1, 1'b0, 32'd4, 32'h0);
        n_checks++;
        if (read_data !== 32'hFFFFFFFB) begin
            n_fail++;
            $display("FAIL rd_on_4 got %h want %h", read_data, 32'hFFFFFFFB);
        end
    endtask

    task automatic test_alias();
        drive(1'b0, 1'b1, 32'h00000101, 32'hDEADBEEF);
        edge_step();
        drive(1'b1, 1'b0, 32'd1, 32'h0);
        n_checks++;
        if (read_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alias_low got %h want %h", read_data, 32'hDEADBEEF);
        end
        address = 32'hFFFF_FF01;
        #1;
        n_checks++;
        if (read_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL alias_high got %h want %h", read_data, 32'hDEADBEEF);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] addrs [4];
        addrs = '{32'd1, 32'd2, 32'd4, 32'd8};
        foreach (addrs[k]) begin
            drive(1'b0, 1'b1, addrs[k], 32'hA5A5_0000 | addrs[k]);
            edge_step();
        end
        drive(1'b1, 1'b0, 32'd8, 32'h0);
        n_checks++;
        if (read_data !== 32'hA5A5_0008) begin
            n_fail++;
            $display("FAIL pre_rst_8 got %h want %h", read_data, 32'hA5A50008);
        end
        memwrite   = 1'b1;
        address    = 32'd4;
        write_data = 32'h5555_5555;
        #1;
        rst_n = 1'b0;
        model_reset();
        memwrite = 1'b0;
        foreach (addrs[k]) begin
            address = addrs[k];
            #0.5;
            n_checks++;
            if (read_data !== addrs[k]) begin
                n_fail++;
                $display("FAIL midrst_rd a=%0d got %h want %h",
                         addrs[k], read_data, addrs[k]);
            end
        end
        memwrite = 1'b1;
        address  = 32'd4;
        repeat (2) edge_step();
        @(negedge clk);
        memwrite = 1'b0;
        rst_n    = 1'b1;
        #1;
        n_checks++;
        if (read_data !== 32'h00000004) begin
            n_fail++;
            $display("FAIL rst_blocks_wr got %h want %h", read_data, 32'h4);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom), 1'($urandom),
                  {$urandom_range(3, 0) == 0 ? $urandom : 32'h0, 8'h0} |
                  32'($urandom_range(255, 0)),
                  $urandom);
            exp = model_read();
            n_checks++;
            if (read_data !== exp) begin
                n_fail++;
                $display("FAIL random n=%0d a=%h mr=%b mw=%b got %h want %h",
                         n, address, memread, memwrite, read_data, exp);
            end
            edge_step();
        end
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 32'(i), 32'h0);
            n_checks++;
            if (read_data !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL sweep i=%0d got %h want %h",
                         i, read_data, ref_mem[i]);
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        memread    = 1'b0;
        memwrite   = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        model_reset();
        test_reset();
        test_write_read();
        test_same_cycle();
        test_read_disable();
        test_alias();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
